// File: rtl/tow_pkg.sv
// tow_pkg: shared tug-of-war types and default constants.
package tow_pkg;
    localparam int SCORE_W_DEF     = 3;
    localparam int WIN_SCORE_DEF   = 7;
    localparam int HOLD_CYCLES_DEF = 4;
    typedef logic [SCORE_W_DEF-1:0] score_t;
    typedef enum logic [1:0] {SERVE, PLAY, HOLD, DONE} state_t;
endpackage

// File: rtl/match_controller_if.sv
// match_controller_if: match controller inputs and scoreboard/light-chain outputs.
interface match_controller_if #(parameter int SCORE_W = 3) ();
    logic               start, winL, winR;
    logic               round_reset, play_en, point_pulse, match_over, winner_left;
    logic [SCORE_W-1:0] scoreL, scoreR;
    modport slave  (input  start, winL, winR,
                    output round_reset, play_en, point_pulse, match_over, winner_left, scoreL, scoreR);
    modport master (output start, winL, winR,
                    input  round_reset, play_en, point_pulse, match_over, winner_left, scoreL, scoreR);
endinterface

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that stops at zero.
module hold_timer #(
    parameter int W = 3
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - W'(1);
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/match_controller.sv
// match_controller: tug-of-war point scoring, post-point freeze and match end sequencing.
module match_controller import tow_pkg::*; #(
    parameter int SCORE_W     = SCORE_W_DEF,
    parameter int WIN_SCORE   = WIN_SCORE_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int HOLD_W      = 3
) (
    input logic               Clock,
    input logic               Reset,
    match_controller_if.slave bus
);
    state_t             state, state_n;
    logic [SCORE_W-1:0] inc_l, inc_r;
    logic               hit_l, hit_r, win, load, zero;
    assign inc_l = bus.scoreL + SCORE_W'(1);
    assign inc_r = bus.scoreR + SCORE_W'(1);
    // Simultaneous wins cancel each other out.
    assign hit_l = state == PLAY && bus.winL && !bus.winR;
    assign hit_r = state == PLAY && bus.winR && !bus.winL;
    assign win   = hit_l ? inc_l == SCORE_W'(WIN_SCORE) : inc_r == SCORE_W'(WIN_SCORE);
    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            SERVE: state_n = PLAY;
            PLAY: if (hit_l || hit_r) begin
                state_n = win ? DONE : HOLD;
                load    = !win;
            end
            HOLD: state_n = zero ? SERVE : HOLD;
            DONE: state_n = DONE;
        endcase
        if (bus.start) state_n = SERVE;
    end
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state           <= SERVE;
            bus.scoreL      <= '0;
            bus.scoreR      <= '0;
            bus.point_pulse <= 1'b0;
            bus.winner_left <= 1'b0;
        end else if (bus.start) begin
            state           <= SERVE;
            bus.scoreL      <= '0;
            bus.scoreR      <= '0;
            bus.point_pulse <= 1'b0;
            bus.winner_left <= 1'b0;
        end else begin
            state           <= state_n;
            bus.point_pulse <= hit_l || hit_r;
            if (hit_l) bus.scoreL <= inc_l;
            if (hit_r) bus.scoreR <= inc_r;
            if ((hit_l || hit_r) && win) bus.winner_left <= hit_l;
        end
    end
    hold_timer #(.W(HOLD_W)) u_hold (
        .Clock    (Clock),
        .Reset    (Reset),
        .load     (load),
        .en       (state == HOLD),
        .load_val (HOLD_W'(HOLD_CYCLES - 1)),
        .zero     (zero)
    );
    assign bus.round_reset = state == SERVE;
    assign bus.play_en     = state == PLAY;
    assign bus.match_over  = state == DONE;
endmodule
